// File: rtl/dt_integrator.sv
// Integrates a scaled Q7.0 derivative stream back into an absolute Q7.0 estimate.
// Optional leak toward the seed value is enabled by defining DT_INTEG_LEAK_EN.
module dt_integrator #(
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic [7:0] i_T_seed,
    input  logic [7:0] i_dT_in,
    input  logic       i_dt_valid,
    input  logic [2:0] i_k_dt,
    input  logic [7:0] i_t_min,
    input  logic [7:0] i_t_max,
    output logic [7:0] o_T_est,
    output logic       o_t_valid,
    output logic       o_sat,
    output logic       o_stale
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    localparam logic [15:0] TO_C = 16'(TIMEOUT);

    state_e                   r_state, w_state_next;
    logic signed [ACC_W-1:0]  r_acc, w_acc_next;
    logic        [15:0]       r_cnt, w_cnt_next;
    logic        [7:0]        r_T_est, w_T_est_next;
    logic                     r_t_valid, w_t_valid_next;
    logic                     r_sat, w_sat_next;
    logic                     r_stale, w_stale_next;

    logic                     w_accept;
    logic signed [15:0]       w_seed16;
    logic signed [ACC_W-1:0]  w_seed_load;
    logic signed [23:0]       w_dt_ext;
    logic signed [23:0]       w_step;
    logic signed [23:0]       w_sum;
    logic signed [23:0]       w_leaked;
    logic signed [23:0]       w_hi;
    logic signed [23:0]       w_lo;
    logic signed [23:0]       w_upper;
    logic signed [23:0]       w_clamp;
    logic                     w_clip;
    logic        [15:0]       w_cnt_inc;

`ifdef DT_INTEG_LEAK_EN
    logic signed [ACC_W-1:0]  r_seed, w_seed_next;
    logic signed [23:0]       w_diff;
`endif

    assign w_accept    = i_dt_valid & ~i_init & (r_state != StIdle);
    assign w_seed16    = {i_T_seed, 8'h00};
    assign w_seed_load = ACC_W'(w_seed16);
    assign w_dt_ext    = 24'(signed'(i_dT_in));
    assign w_step      = w_dt_ext <<< (5'd8 + 5'(i_k_dt));
    assign w_sum       = 24'(r_acc) + w_step;

`ifdef DT_INTEG_LEAK_EN
    // Pulls the accumulator toward the seed so truncation error cannot drift unbounded.
    assign w_diff      = w_sum - 24'(r_seed);
    assign w_leaked    = w_sum - (w_diff >>> LEAK_SHIFT);
`else
    assign w_leaked    = w_sum;
`endif

    assign w_hi    = {{8{i_t_max[7]}}, i_t_max, 8'h00};
    assign w_lo    = {{8{i_t_min[7]}}, i_t_min, 8'h00};
    // Lower bound applied last so an inverted window pins to t_min.
    assign w_upper = (w_leaked > w_hi) ? w_hi : w_leaked;
    assign w_clamp = (w_upper < w_lo) ? w_lo : w_upper;
    assign w_clip  = (w_clamp != w_leaked);

    assign w_cnt_inc = r_cnt + 16'd1;

    always_comb begin
        w_state_next   = r_state;
        w_acc_next     = r_acc;
        w_cnt_next     = r_cnt;
        w_T_est_next   = r_T_est;
        w_t_valid_next = 1'b0;
        w_sat_next     = r_sat;
        w_stale_next   = r_stale;
`ifdef DT_INTEG_LEAK_EN
        w_seed_next    = r_seed;
`endif
        if (i_init) begin
            w_state_next = StRun;
            w_acc_next   = w_seed_load;
            w_cnt_next   = 16'd0;
            w_T_est_next = i_T_seed;
            w_sat_next   = 1'b0;
            w_stale_next = 1'b0;
`ifdef DT_INTEG_LEAK_EN
            w_seed_next  = w_seed_load;
`endif
        end else if (w_accept) begin
            w_state_next   = StRun;
            w_acc_next     = w_clamp[ACC_W-1:0];
            w_cnt_next     = 16'd0;
            w_T_est_next   = w_clamp[15:8];
            w_t_valid_next = 1'b1;
            w_sat_next     = w_clip;
            w_stale_next   = 1'b0;
        end else if (r_state != StIdle) begin
            if (r_cnt != TO_C) begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc == TO_C) begin
                    w_state_next = StHold;
                    w_stale_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_cnt     <= 16'd0;
            r_T_est   <= 8'd0;
            r_t_valid <= 1'b0;
            r_sat     <= 1'b0;
            r_stale   <= 1'b0;
`ifdef DT_INTEG_LEAK_EN
            r_seed    <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_T_est   <= w_T_est_next;
            r_t_valid <= w_t_valid_next;
            r_sat     <= w_sat_next;
            r_stale   <= w_stale_next;
`ifdef DT_INTEG_LEAK_EN
            r_seed    <= w_seed_next;
`endif
        end
    end

    assign o_T_est   = r_T_est;
    assign o_t_valid = r_t_valid;
    assign o_sat     = r_sat;
    assign o_stale   = r_stale;

endmodule

// File: tb/tb_dt_integrator.sv
// Scoreboard bench for dt_integrator: stimulus queues expected updates, a monitor
// pops and compares on every t_valid pulse.
module tb_dt_integrator;

    logic       clk;
    logic       rst;
    logic       init;
    logic [7:0] T_seed;
    logic [7:0] dT_in;
    logic       dt_valid;
    logic [2:0] k_dt;
    logic [7:0] t_min;
    logic [7:0] t_max;
    logic [7:0] T_est;
    logic       t_valid;
    logic       sat;
    logic       stale;

    typedef struct {
        int exp_t;
        int exp_sat;
        string name;
    } exp_t_s;

    exp_t_s sb_q[$];
    int total = 0;
    int bad   = 0;

    dt_integrator #(
        .ACC_W     (16),
        .TIMEOUT   (16),
        .LEAK_SHIFT(2)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_init    (init),
        .i_T_seed  (T_seed),
        .i_dT_in   (dT_in),
        .i_dt_valid(dt_valid),
        .i_k_dt    (k_dt),
        .i_t_min   (t_min),
        .i_t_max   (t_max),
        .o_T_est   (T_est),
        .o_t_valid (t_valid),
        .o_sat     (sat),
        .o_stale   (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && t_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected t_valid", 1, 0);
            end else begin
                exp_t_s e;
                e = sb_q.pop_front();
                check({e.name, " T_est"}, int'($signed(T_est)), e.exp_t);
                check({e.name, " sat"}, int'(sat), e.exp_sat);
                check({e.name, " stale"}, int'(stale), 0);
            end
        end
    end

    task automatic do_init(input int seed);
        @(negedge clk);
        init     = 1'b1;
        T_seed   = 8'(seed);
        dt_valid = 1'b0;
        @(negedge clk);
        init = 1'b0;
        check("init T_est", int'($signed(T_est)), seed);
        check("init t_valid", int'(t_valid), 0);
    endtask

    // Leaves dt_valid high so consecutive calls give back-to-back samples.
    task automatic sample(input string name, input int dt, input int k, input int lo,
                          input int hi, input int exp_t, input int exp_sat);
        exp_t_s e;
        dT_in    = 8'(dt);
        k_dt     = 3'(k);
        t_min    = 8'(lo);
        t_max    = 8'(hi);
        dt_valid = 1'b1;
        e.exp_t   = exp_t;
        e.exp_sat = exp_sat;
        e.name    = name;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dt_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; T_seed = '0; dT_in = '0; dt_valid = 1'b0;
        k_dt = '0; t_min = 8'sd0; t_max = 8'sd0;
        repeat (3) @(negedge clk);
        check("reset T_est", int'(T_est), 0);
        check("reset t_valid", int'(t_valid), 0);
        check("reset sat", int'(sat), 0);
        check("reset stale", int'(stale), 0);
        rst = 1'b0;

        // dt_valid in IDLE is ignored
        @(negedge clk);
        sb_q.delete();
        dT_in = 8'd9; k_dt = 3'd0; t_min = 8'h80; t_max = 8'h7f; dt_valid = 1'b1;
        @(negedge clk);
        dt_valid = 1'b0;
        @(negedge clk);
        check("idle T_est", int'(T_est), 0);
        check("idle stale", int'(stale), 0);

`ifndef DT_INTEG_LEAK_EN
        do_init(20);
        sample("ramp1", 3, 0, -128, 127, 23, 0);
        sample("ramp2", 3, 0, -128, 127, 26, 0);
        sample("ramp3", 3, 0, -128, 127, 29, 0);
        sample("ramp4", 3, 0, -128, 127, 32, 0);
        idle(2);

        do_init(-10);
        sample("scale neg", -5, 2, -128, 127, -30, 0);
        sample("scale pos", 1, 2, -128, 127, -26, 0);
        idle(2);

        do_init(45);
        sample("clamp hi", 10, 0, -128, 50, 50, 1);
        sample("clamp rel", -2, 0, -128, 50, 48, 0);
        sample("inverted win", 0, 0, 10, 0, 10, 1);
        idle(2);

        t_min = 8'h80; t_max = 8'h7f;
        do_init(0);
        repeat (15) @(negedge clk);
        check("stale before timeout", int'(stale), 0);
        @(negedge clk);
        check("stale at timeout", int'(stale), 1);
        check("hold T_est", int'(T_est), 0);
        idle(3);
        check("stale held", int'(stale), 1);
        sample("resume", 7, 0, -128, 127, 7, 0);
        idle(1);

        do_init(40);
        check("pre-drop T_est", int'($signed(T_est)), 40);
        init = 1'b1; T_seed = 8'd5; dT_in = 8'd9; dt_valid = 1'b1;
        @(negedge clk);
        init = 1'b0; dt_valid = 1'b0;
        check("drop T_est", int'(T_est), 5);
        check("drop t_valid", int'(t_valid), 0);
        idle(2);
        check("drop hold", int'(T_est), 5);

        // Asynchronous reset mid-operation
        sample("pre-reset", 3, 0, -128, 127, 8, 0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("midreset T_est", int'(T_est), 0);
        check("midreset sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after reset T_est", int'(T_est), 0);
`else
        do_init(0);
        sample("leak1", 64, 0, -128, 127, 48, 0);
        sample("leak2", 0, 0, -128, 127, 36, 0);
        sample("leak3", 0, 0, -128, 127, 27, 0);
        idle(2);
`endif

        idle(2);
        check("scoreboard drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
